// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline WB (1-cycle, no backpressure) vs FIFO-buffered long-latency results (2-cycle min, lu_ready_o low when full).
// stall_o requests a one-cycle WB bubble after STARVE_LIMIT lost cycles; `define WB_SCOREBOARD_EN adds pending_o.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wb_valid_i,
    input  logic [4:0]                 wb_addr_i,
    input  logic [31:0]                wb_data_i,
    input  logic                       lu_valid_i,
    output logic                       lu_ready_o,
    input  logic [4:0]                 lu_addr_i,
    input  logic [31:0]                lu_data_i,
    output logic                       RegWrite_o,
    output logic [4:0]                 WRaddr_o,
    output logic [31:0]                WRdata_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [31:0]                pending_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;
    logic          wr_q, wr_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          fifo_ne, wb_req, push, pop;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_ne    = (count_q != '0);
    assign lu_ready_o = (count_q != FULL);
    assign wb_req     = wb_valid_i && (wb_addr_i != 5'd0);
    // Writes to r0 complete the handshake but never occupy a slot.
    assign push       = lu_valid_i && lu_ready_o && (lu_addr_i != 5'd0);

    always_comb begin
        pop      = 1'b0;
        wr_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        stall_d  = 1'b0;
        starve_d = starve_q;

        if (stall_q && fifo_ne) begin
            pop = 1'b1;
        end else if (wb_req) begin
            wr_d    = 1'b1;
            waddr_d = wb_addr_i;
            wdata_d = wb_data_i;
        end else if (fifo_ne) begin
            pop = 1'b1;
        end

        if (pop) begin
            wr_d    = 1'b1;
            waddr_d = head.addr;
            wdata_d = head.data;
        end

        if (stall_q && wb_req) begin
            err_d = 1'b1;
        end

        // Reaching here with a non-empty FIFO and no pop means the pipeline won.
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (starve_q == STARVE_LAST) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = starve_q + SW'(1);
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: lu_addr_i, data: lu_data_i};
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign RegWrite_o = wr_q;
    assign WRaddr_o   = waddr_q;
    assign WRdata_o   = wdata_q;
    assign stall_o    = stall_q;
    assign count_o    = count_q;
    assign err_o      = err_q;

`ifdef WB_SCOREBOARD_EN
    logic [CW-1:0] pend_q [32];
    logic [CW-1:0] pend_d [32];

    always_comb begin
        pending_o = '0;
        for (int r = 0; r < 32; r++) begin
            pend_d[r] = pend_q[r];
            if (push && (lu_addr_i == 5'(r))) begin
                pend_d[r] = pend_d[r] + CW'(1);
            end
            if (pop && (head.addr == 5'(r))) begin
                pend_d[r] = pend_d[r] - CW'(1);
            end
            pending_o[r] = (r != 0) && (pend_q[r] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected writes queued when stimulus is driven, checked when RegWrite_o fires.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic          clk_i;
    logic          rst_i;
    logic          wb_valid_i;
    logic [4:0]    wb_addr_i;
    logic [31:0]   wb_data_i;
    logic          lu_valid_i;
    logic          lu_ready_o;
    logic [4:0]    lu_addr_i;
    logic [31:0]   lu_data_i;
    logic          RegWrite_o;
    logic [4:0]    WRaddr_o;
    logic [31:0]   WRdata_o;
    logic          stall_o;
    logic [CW-1:0] count_o;
    logic          err_o;
`ifdef WB_SCOREBOARD_EN
    logic [31:0]   pending_o;
`endif

    int  n_checks = 0;
    int  n_pass   = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_valid_i (wb_valid_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .lu_valid_i (lu_valid_i),
        .lu_ready_o (lu_ready_o),
        .lu_addr_i  (lu_addr_i),
        .lu_data_i  (lu_data_i),
        .RegWrite_o (RegWrite_o),
        .WRaddr_o   (WRaddr_o),
        .WRdata_o   (WRdata_o),
        .stall_o    (stall_o),
        .count_o    (count_o),
        .err_o      (err_o)
`ifdef WB_SCOREBOARD_EN
        ,
        .pending_o  (pending_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Output monitor: every register-file write must match the oldest expectation.
    always begin
        @(posedge clk_i);
        #1;
        if (RegWrite_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got addr=%0d data=%h, no write expected", WRaddr_o, WRdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (WRaddr_o !== mon_e.addr || WRdata_o !== mon_e.data)
                    $display("FAIL wr_value: got addr=%0d data=%h, want addr=%0d data=%h", WRaddr_o, WRdata_o, mon_e.addr, mon_e.data);
                else n_pass++;
            end
        end
    end

    task automatic drive_idle();
        wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        lu_valid_i = 1'b0; lu_addr_i = '0; lu_data_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_idle();
        @(negedge clk_i);
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL rst_regwrite: got %b want 0", RegWrite_o); else n_pass++;
        n_checks++; if (WRaddr_o !== 5'd0) $display("FAIL rst_waddr: got %0d want 0", WRaddr_o); else n_pass++;
        n_checks++; if (WRdata_o !== 32'd0) $display("FAIL rst_wdata: got %h want 0", WRdata_o); else n_pass++;
        n_checks++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (count_o !== 3'd0) $display("FAIL rst_count: got %0d want 0", count_o); else n_pass++;
        n_checks++; if (lu_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", lu_ready_o); else n_pass++;
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL rst_post_write: got %b want 0", RegWrite_o); else n_pass++;
    endtask

    task automatic test_wb_single();
        @(negedge clk_i);
        wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
        exp_q.push_back(wr_t'{5'd5, 32'hDEADBEEF});
        @(negedge clk_i);
        drive_idle();
        n_checks++; if (RegWrite_o !== 1'b1) $display("FAIL wb_write: got %b want 1", RegWrite_o); else n_pass++;
        n_checks++; if (WRaddr_o !== 5'd5) $display("FAIL wb_addr: got %0d want 5", WRaddr_o); else n_pass++;
        n_checks++; if (WRdata_o !== 32'hDEADBEEF) $display("FAIL wb_data: got %h want deadbeef", WRdata_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL wb_idle: got %b want 0", RegWrite_o); else n_pass++;
        n_checks++; if (WRaddr_o !== 5'd5) $display("FAIL wb_hold_addr: got %0d want 5", WRaddr_o); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL wb_drain: %0d writes missing, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_lu_order();
        @(negedge clk_i);
        lu_valid_i = 1'b1; lu_addr_i = 5'd7; lu_data_i = 32'h11;
        exp_q.push_back(wr_t'{5'd7, 32'h11});
        @(negedge clk_i);
        n_checks++; if (count_o !== 3'd1) $display("FAIL lu_count_a: got %0d want 1", count_o); else n_pass++;
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL lu_early: got %b want 0", RegWrite_o); else n_pass++;
`ifdef WB_SCOREBOARD_EN
        n_checks++; if (pending_o !== 32'h80) $display("FAIL lu_pending: got %h want 00000080", pending_o); else n_pass++;
`endif
        lu_addr_i = 5'd9; lu_data_i = 32'h22;
        exp_q.push_back(wr_t'{5'd9, 32'h22});
        @(negedge clk_i);
        drive_idle();
        n_checks++; if (RegWrite_o !== 1'b1 || WRaddr_o !== 5'd7) $display("FAIL lu_first: got we=%b addr=%0d want we=1 addr=7", RegWrite_o, WRaddr_o); else n_pass++;
        n_checks++; if (count_o !== 3'd1) $display("FAIL lu_count_b: got %0d want 1", count_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (RegWrite_o !== 1'b1 || WRaddr_o !== 5'd9) $display("FAIL lu_second: got we=%b addr=%0d want we=1 addr=9", RegWrite_o, WRaddr_o); else n_pass++;
        n_checks++; if (count_o !== 3'd0) $display("FAIL lu_count_c: got %0d want 0", count_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL lu_idle: got %b want 0", RegWrite_o); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL lu_drain: %0d writes missing, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_zero_addr();
        @(negedge clk_i);
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h5555;
        lu_valid_i = 1'b1; lu_addr_i = 5'd0; lu_data_i = 32'h6666;
        n_checks++; if (lu_ready_o !== 1'b1) $display("FAIL zero_ready: got %b want 1", lu_ready_o); else n_pass++;
        @(negedge clk_i);
        drive_idle();
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL zero_write: got %b want 0", RegWrite_o); else n_pass++;
        n_checks++; if (count_o !== 3'd0) $display("FAIL zero_count_a: got %0d want 0", count_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL zero_write_b: got %b want 0", RegWrite_o); else n_pass++;
        n_checks++; if (count_o !== 3'd0) $display("FAIL zero_count_b: got %0d want 0", count_o); else n_pass++;
    endtask

    task automatic test_starve();
        // Fill the FIFO under a continuously busy pipeline; 8 lost cycles (k=2..9) force a stall in k=10.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            n_checks++; if (stall_o !== 1'b0) $display("FAIL starve_early_stall k=%0d: got %b want 0", k, stall_o); else n_pass++;
            if (k >= 5) begin
                n_checks++; if (count_o !== 3'd4 || lu_ready_o !== 1'b0) $display("FAIL starve_full k=%0d: got count=%0d rdy=%b want 4/0", k, count_o, lu_ready_o); else n_pass++;
            end
            wb_valid_i = 1'b1; wb_addr_i = 5'(k); wb_data_i = 32'hB000 + 32'(k);
            exp_q.push_back(wr_t'{5'(k), 32'hB000 + 32'(k)});
            lu_valid_i = (k <= 4); lu_addr_i = 5'(9 + k); lu_data_i = 32'hA0 + 32'(k - 1);
        end
        @(negedge clk_i);
        n_checks++; if (stall_o !== 1'b1) $display("FAIL starve_stall: got %b want 1", stall_o); else n_pass++;
        drive_idle();
        exp_q.push_back(wr_t'{5'd10, 32'hA0});
        @(negedge clk_i);
        n_checks++; if (stall_o !== 1'b0) $display("FAIL starve_pulse: got %b want 0", stall_o); else n_pass++;
        n_checks++; if (count_o !== 3'd3 || lu_ready_o !== 1'b1) $display("FAIL starve_pop: got count=%0d rdy=%b want 3/1", count_o, lu_ready_o); else n_pass++;
        n_checks++; if (WRaddr_o !== 5'd10 || WRdata_o !== 32'hA0) $display("FAIL starve_head: got %0d/%h want 10/000000a0", WRaddr_o, WRdata_o); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back(wr_t'{5'(11 + j), 32'hA1 + 32'(j)});
            @(negedge clk_i);
        end
        n_checks++; if (count_o !== 3'd0) $display("FAIL starve_empty: got %0d want 0", count_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (exp_q.size() != 0) $display("FAIL starve_drain: %0d writes missing, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_stall_violation();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                n_checks++; if (err_o !== 1'b0) $display("FAIL viol_err_pre: got %b want 0", err_o); else n_pass++;
            end
            wb_valid_i = 1'b1; wb_addr_i = 5'(k); wb_data_i = 32'hC000 + 32'(k);
            exp_q.push_back(wr_t'{5'(k), 32'hC000 + 32'(k)});
            lu_valid_i = (k == 1); lu_addr_i = 5'd20; lu_data_i = 32'hC0;
        end
        @(negedge clk_i);
        n_checks++; if (stall_o !== 1'b1) $display("FAIL viol_stall: got %b want 1", stall_o); else n_pass++;
        // Pipeline ignores the stall: its write to r3 must be dropped.
        wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h333; lu_valid_i = 1'b0;
        exp_q.push_back(wr_t'{5'd20, 32'hC0});
        @(negedge clk_i);
        drive_idle();
        n_checks++; if (err_o !== 1'b1) $display("FAIL viol_err: got %b want 1", err_o); else n_pass++;
        n_checks++; if (RegWrite_o !== 1'b1 || WRaddr_o !== 5'd20) $display("FAIL viol_head: got we=%b addr=%0d want 1/20", RegWrite_o, WRaddr_o); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_i);
            n_checks++; if (err_o !== 1'b1) $display("FAIL viol_sticky j=%0d: got %b want 1", j, err_o); else n_pass++;
            n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL viol_nowrite j=%0d: got %b want 0", j, RegWrite_o); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL viol_drain: %0d writes missing, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (k == 5) begin
                n_checks++; if (count_o !== 3'd4) $display("FAIL mrst_fill: got %0d want 4", count_o); else n_pass++;
                drive_idle();
                exp_q.push_back(wr_t'{5'd21, 32'hE1});
            end else begin
                wb_valid_i = 1'b1; wb_addr_i = 5'(k); wb_data_i = 32'hD000 + 32'(k);
                exp_q.push_back(wr_t'{5'(k), 32'hD000 + 32'(k)});
                lu_valid_i = 1'b1; lu_addr_i = 5'(20 + k); lu_data_i = 32'hE0 + 32'(k);
            end
        end
        @(negedge clk_i);
        n_checks++; if (count_o !== 3'd3) $display("FAIL mrst_count_pre: got %0d want 3", count_o); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL mrst_err_pre: got %b want 1", err_o); else n_pass++;
`ifdef WB_SCOREBOARD_EN
        n_checks++; if (pending_o !== 32'h01C0_0000) $display("FAIL mrst_pending_pre: got %h want 01c00000", pending_o); else n_pass++;
`endif
        rst_i = 1'b1;
        #1;
        n_checks++; if (RegWrite_o !== 1'b0 || WRaddr_o !== 5'd0 || WRdata_o !== 32'd0) $display("FAIL mrst_outputs: got %b/%0d/%h want 0/0/0", RegWrite_o, WRaddr_o, WRdata_o); else n_pass++;
        n_checks++; if (count_o !== 3'd0 || lu_ready_o !== 1'b1) $display("FAIL mrst_count: got %0d rdy=%b want 0/1", count_o, lu_ready_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0 || stall_o !== 1'b0) $display("FAIL mrst_flags: got err=%b stall=%b want 0/0", err_o, stall_o); else n_pass++;
`ifdef WB_SCOREBOARD_EN
        n_checks++; if (pending_o !== 32'd0) $display("FAIL mrst_pending: got %h want 0", pending_o); else n_pass++;
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_i);
            n_checks++; if (RegWrite_o !== 1'b0 || count_o !== 3'd0) $display("FAIL mrst_after j=%0d: got we=%b count=%0d want 0/0", j, RegWrite_o, count_o); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL mrst_queue: %0d writes missing, want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();
        test_reset();
        test_wb_single();
        test_lu_order();
        test_zero_addr();
        test_starve();
        test_stall_violation();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
